// File: rtl/sine_ctrl_pkg.sv
// sine_ctrl_pkg: sequencer states and default widths shared with sine_wave_generator
package sine_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
    localparam int DEF_PHASE_W = 10;
    localparam int DEF_ACC_W   = 16;
    localparam int DEF_CNT_W   = 12;
    localparam int DEF_GAP_W   = 8;
    localparam int DEF_LUT_LAT = 1;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-stage shift register with synchronous clear
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clock)
        sr <= clear ? '0 : DEPTH'({sr, din});
    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/sine_tone_sequencer.sv
// sine_tone_sequencer: turns tone commands into a phase stream for the sine LUT
module sine_tone_sequencer
    import sine_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int LUT_LAT = DEF_LUT_LAT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ACC_W-1:0]   cmd_incr,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic [GAP_W-1:0]   cmd_gap,
    input  logic               abort,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               lut_valid,
    output logic               busy,
    output logic               done,
    output logic               aborted
);
    state_t state, state_next;
    logic [ACC_W-1:0] acc, incr_q;
    logic [CNT_W-1:0] remaining;
    logic [GAP_W-1:0] gap_cnt;
    logic accept, kill, last;

    assign cmd_ready   = state == IDLE && !reset && !abort;
    assign accept      = cmd_valid && cmd_ready;
    assign kill        = abort && state != IDLE;
    assign last        = state == RUN && remaining == '0;
    assign busy        = state != IDLE;
    assign phase_valid = state == RUN;

    always_comb begin
        state_next = state;
        if (kill)
            state_next = IDLE;
        else if (state == IDLE)
            state_next = accept && cmd_count != '0 ? RUN : IDLE;
        else if (state == RUN)
            state_next = !last ? RUN : gap_cnt != '0 ? GAP : IDLE;
        else
            state_next = gap_cnt > GAP_W'(1) ? GAP : IDLE;
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_next;

    // acc runs one sample ahead of phase, so phase can be registered directly from it
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            incr_q    <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            phase     <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else if (kill) begin
            acc     <= '0;
            phase   <= '0;
            done    <= 1'b0;
            aborted <= 1'b1;
        end else begin
            done    <= last || (accept && cmd_count == '0);
            aborted <= 1'b0;
            if (accept) begin
                incr_q    <= cmd_incr;
                acc       <= cmd_incr;
                remaining <= cmd_count - CNT_W'(1);
                gap_cnt   <= cmd_gap;
                if (cmd_count != '0)
                    phase <= '0;
            end else if (state == RUN && !last) begin
                phase     <= acc[ACC_W-1 -: PHASE_W];
                acc       <= acc + incr_q;
                remaining <= remaining - CNT_W'(1);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    valid_delay_line #(.DEPTH(LUT_LAT)) u_lut_valid (
        .clock (clock),
        .clear (reset || kill),
        .din   (phase_valid),
        .dout  (lut_valid)
    );
endmodule

// File: tb/tb_sine_tone_sequencer.sv
// tb_sine_tone_sequencer: directed plus random commands checked against a cycle schedule model
module tb_sine_tone_sequencer;
    localparam int LAT = 1;
    localparam int N   = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cmd_incr = '0;
    logic [11:0] cmd_count = '0;
    logic [7:0]  cmd_gap = '0;
    logic        cmd_ready, phase_valid, lut_valid, busy, done, aborted;
    logic [9:0]  phase;

    sine_tone_sequencer #(.LUT_LAT(LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_incr    (cmd_incr),
        .cmd_count   (cmd_count),
        .cmd_gap     (cmd_gap),
        .abort       (abort),
        .phase       (phase),
        .phase_valid (phase_valid),
        .lut_valid   (lut_valid),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clock = ~clock;

    // expected outputs scheduled per cycle number when a command or abort is seen
    bit pv_s[N], lut_s[N], busy_s[N], done_s[N], abt_s[N], zero_s[N];
    int ph_s[N];
    int cyc = 0, idle_from = 1, held = 0, n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic cycle(input logic r, input logic v, input int incr, input int cnt,
                         input int gap, input logic ab);
        bit rdy;
        @(posedge clock);
        #1;
        cyc++;
        reset = r;
        cmd_valid = v;
        cmd_incr = 16'(incr);
        cmd_count = 12'(cnt);
        cmd_gap = 8'(gap);
        abort = ab;
        @(negedge clock);
        if (zero_s[cyc]) held = 0;
        if (pv_s[cyc]) held = ph_s[cyc];
        rdy = !r && !ab && cyc >= idle_from;
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, rdy});
        check("phase_valid", {31'd0, phase_valid}, {31'd0, pv_s[cyc]});
        check("phase", {22'd0, phase}, held);
        check("lut_valid", {31'd0, lut_valid}, {31'd0, lut_s[cyc]});
        check("busy", {31'd0, busy}, {31'd0, busy_s[cyc]});
        check("done", {31'd0, done}, {31'd0, done_s[cyc]});
        check("aborted", {31'd0, aborted}, {31'd0, abt_s[cyc]});
        check("done_with_aborted", {31'd0, done & aborted}, 0);
        if (r || (ab && busy_s[cyc])) begin
            for (int i = cyc + 1; i < N; i++) begin
                pv_s[i] = 0; lut_s[i] = 0; busy_s[i] = 0; done_s[i] = 0; abt_s[i] = 0;
            end
            zero_s[cyc+1] = 1;
            abt_s[cyc+1] = !r;
            idle_from = cyc + 1;
        end else if (rdy && v) begin
            if (cnt == 0) begin
                done_s[cyc+1] = 1;
                idle_from = cyc + 1;
            end else begin
                for (int k = 0; k < cnt; k++) begin
                    pv_s[cyc+1+k] = 1;
                    ph_s[cyc+1+k] = ((k * (incr & 32'hFFFF)) & 32'hFFFF) >> 6;
                    lut_s[cyc+1+k+LAT] = 1;
                end
                for (int i = cyc + 1; i <= cyc + cnt + gap; i++) busy_s[i] = 1;
                done_s[cyc+cnt+1] = 1;
                idle_from = cyc + cnt + gap + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'h0400, 4, 0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0400, 4, 0, 1'b0);
        idle(6);
        cycle(1'b0, 1'b1, 16'h8000, 3, 0, 1'b0);
        idle(5);
        cycle(1'b0, 1'b1, 16'h1234, 0, 0, 1'b0);
        idle(2);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 16'h0040, 4, 3, 1'b0);
        idle(14);
        cycle(1'b0, 1'b1, 16'h0123, 10, 0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b1);
        idle(3);
        cycle(1'b0, 1'b1, 16'h0200, 2, 0, 1'b1);
        idle(2);
        cycle(1'b0, 1'b1, 16'h0300, 10, 0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 0, 0, 0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0300, 3, 0, 1'b0);
        idle(5);
        while (cyc < N - 64)
            cycle($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)),
                  int'($urandom_range(0, 4)), $urandom_range(0, 29) == 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
